// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and helpers for the byte-enable dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        RD_FIRST = 1'b0,
        WR_FIRST = 1'b1
    } rd_mode_e;

    // Widest word byte_merge handles; callers widen and truncate with casts.
    localparam int MAX_W  = 1024;
    localparam int MAX_BE = MAX_W / 8;

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] r;
        r = old_w;
        for (int k = 0; k < MAX_BE; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram_out_stage.sv
// dpram_out_stage: optional output register holding data while not valid.
module dpram_out_stage #(
    parameter int W  = 8,
    parameter bit EN = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    generate
        if (EN) begin : g_reg
            logic         r_valid;
            logic [W-1:0] r_data;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= i_valid;
                    if (i_valid) r_data <= i_data;
                end
            end

            assign o_valid = r_valid;
            assign o_data  = r_data;
        end else begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_valid  = i_valid;
            assign o_data   = i_data;
        end
    endgenerate

endmodule

// File: rtl/dpram_be.sv
// dpram_be: true dual-port RAM with byte enables, read-during-write
// mode select and optional output register.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int       DATA_W  = 8,
    parameter int       ADDR_W  = 3,
    parameter rd_mode_e RD_MODE = RD_FIRST,
    parameter bit       OUT_REG = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_a_en,
    input  logic                i_a_we,
    input  logic [DATA_W/8-1:0] i_a_be,
    input  logic [ADDR_W-1:0]   i_a_addr,
    input  logic [DATA_W-1:0]   i_a_din,
    output logic [DATA_W-1:0]   o_a_dout,
    output logic                o_a_valid,
    input  logic                i_b_en,
    input  logic                i_b_we,
    input  logic [DATA_W/8-1:0] i_b_be,
    input  logic [ADDR_W-1:0]   i_b_addr,
    input  logic [DATA_W-1:0]   i_b_din,
    output logic [DATA_W-1:0]   o_b_dout,
    output logic                o_b_valid,
    output logic                o_collision
);

    localparam int DEPTH = 2**ADDR_W;

    reg [DATA_W-1:0] mem [0:DEPTH-1];

    logic              w_a_wr;
    logic              w_b_wr;
    logic              w_same;
    logic [DATA_W-1:0] w_a_old;
    logic [DATA_W-1:0] w_b_old;
    logic [DATA_W-1:0] w_a_base;
    logic [DATA_W-1:0] w_a_merge;
    logic [DATA_W-1:0] w_b_merge;
    logic [DATA_W-1:0] w_a_new;
    logic [DATA_W-1:0] w_a_rdata;
    logic [DATA_W-1:0] w_b_rdata;

    logic              r_a_valid;
    logic              r_b_valid;
    logic [DATA_W-1:0] r_a_dout;
    logic [DATA_W-1:0] r_b_dout;
    logic              r_coll;

    logic              w_c_valid;
    logic              w_c_data;

    assign w_a_wr  = i_a_en & i_a_we & ~i_rst;
    assign w_b_wr  = i_b_en & i_b_we & ~i_rst;
    assign w_same  = (i_a_addr == i_b_addr);
    assign w_a_old = mem[i_a_addr];
    assign w_b_old = mem[i_b_addr];

    assign w_b_merge = DATA_W'(byte_merge(MAX_W'(w_b_old),
        MAX_W'(i_b_din), MAX_BE'(i_b_be)));

    // A merges on top of B's result so B's non-overlapping bytes survive.
    assign w_a_base  = (w_b_wr && w_same) ? w_b_merge : w_a_old;
    assign w_a_merge = DATA_W'(byte_merge(MAX_W'(w_a_base),
        MAX_W'(i_a_din), MAX_BE'(i_a_be)));
    assign w_a_new   = DATA_W'(byte_merge(MAX_W'(w_a_old),
        MAX_W'(i_a_din), MAX_BE'(i_a_be)));

    assign w_a_rdata = (i_a_we && RD_MODE == WR_FIRST) ? w_a_new : w_a_old;
    assign w_b_rdata = (i_b_we && RD_MODE == WR_FIRST) ? w_b_merge : w_b_old;

    always_ff @(posedge i_clk) begin
        if (w_b_wr) mem[i_b_addr] <= w_b_merge;
        if (w_a_wr) mem[i_a_addr] <= w_a_merge;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_a_dout  <= '0;
            r_b_dout  <= '0;
            r_coll    <= 1'b0;
        end else begin
            r_a_valid <= i_a_en;
            r_b_valid <= i_b_en;
            if (i_a_en) r_a_dout <= w_a_rdata;
            if (i_b_en) r_b_dout <= w_b_rdata;
            r_coll <= i_a_en & i_b_en & w_same & (i_a_we | i_b_we);
        end
    end

    dpram_out_stage #(.W(DATA_W), .EN(OUT_REG)) u_out_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (r_a_valid),
        .i_data  (r_a_dout),
        .o_valid (o_a_valid),
        .o_data  (o_a_dout)
    );

    dpram_out_stage #(.W(DATA_W), .EN(OUT_REG)) u_out_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (r_b_valid),
        .i_data  (r_b_dout),
        .o_valid (o_b_valid),
        .o_data  (o_b_dout)
    );

    dpram_out_stage #(.W(1), .EN(OUT_REG)) u_out_c (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (r_coll),
        .i_data  (r_coll),
        .o_valid (w_c_valid),
        .o_data  (w_c_data)
    );

    assign o_collision = w_c_valid & w_c_data;

endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: three configurations driven in lockstep against a
// reference memory and a queue of expected per-edge results.
module tb_dpram_be;
    import dpram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, a_we, b_en, b_we;
    logic [1:0]  a_be, b_be;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic [15:0] ad [3];
    logic [15:0] bd [3];
    logic        av [3];
    logic        bv [3];
    logic        co [3];

    dpram_be #(.DATA_W(16), .ADDR_W(4), .RD_MODE(RD_FIRST), .OUT_REG(1'b0)) u0 (
        .i_clk(clk), .i_rst(rst),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_be(a_be), .i_a_addr(a_addr),
        .i_a_din(a_din), .o_a_dout(ad[0]), .o_a_valid(av[0]),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr),
        .i_b_din(b_din), .o_b_dout(bd[0]), .o_b_valid(bv[0]),
        .o_collision(co[0]));

    dpram_be #(.DATA_W(16), .ADDR_W(4), .RD_MODE(WR_FIRST), .OUT_REG(1'b0)) u1 (
        .i_clk(clk), .i_rst(rst),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_be(a_be), .i_a_addr(a_addr),
        .i_a_din(a_din), .o_a_dout(ad[1]), .o_a_valid(av[1]),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr),
        .i_b_din(b_din), .o_b_dout(bd[1]), .o_b_valid(bv[1]),
        .o_collision(co[1]));

    dpram_be #(.DATA_W(16), .ADDR_W(4), .RD_MODE(RD_FIRST), .OUT_REG(1'b1)) u2 (
        .i_clk(clk), .i_rst(rst),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_be(a_be), .i_a_addr(a_addr),
        .i_a_din(a_din), .o_a_dout(ad[2]), .o_a_valid(av[2]),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr),
        .i_b_din(b_din), .o_b_dout(bd[2]), .o_b_valid(bv[2]),
        .o_collision(co[2]));

    typedef struct {
        bit          rst;
        bit          av, bv, coll;
        bit          ak, bk;
        logic [15:0] a_rf, a_wf, b_rf, b_wf;
    } rec_t;

    typedef struct {
        logic [15:0] d;
        bit          k;
    } held_t;

    rec_t        sb [$];
    logic [15:0] m  [16];
    bit          kn [16];
    held_t       ha [3];
    held_t       hb [3];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [15:0] mrg(logic [15:0] o, logic [15:0] n,
                                        logic [1:0] be);
        logic [15:0] r;
        r = o;
        if (be[0]) r[7:0]  = n[7:0];
        if (be[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    function automatic logic [15:0] pat(int i);
        logic [3:0] n;
        n = 4'(i);
        case (i)
            3:       return 16'h1234;
            5:       return 16'h0000;
            9:       return 16'h0F0F;
            default: return {n, 4'hA, ~n, 4'h5};
        endcase
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pa(bit en, bit we, logic [1:0] be, int adr, logic [15:0] d);
        a_en = en; a_we = we; a_be = be; a_addr = 4'(adr); a_din = d;
    endtask

    task automatic pb(bit en, bit we, logic [1:0] be, int adr, logic [15:0] d);
        b_en = en; b_we = we; b_be = be; b_addr = 4'(adr); b_din = d;
    endtask

    task automatic check_all();
        rec_t        e;
        logic [15:0] xa, xb;
        for (int i = 0; i < 3; i++) begin
            if (i < 2 || sb[$].rst || sb.size() < 2) e = sb[$];
            else e = sb[$-1];
            xa = (i == 1) ? e.a_wf : e.a_rf;
            xb = (i == 1) ? e.b_wf : e.b_rf;
            if (e.rst) begin
                ha[i] = '{16'h0, 1'b1};
                hb[i] = '{16'h0, 1'b1};
            end else begin
                if (e.av) ha[i] = '{xa, e.ak};
                if (e.bv) hb[i] = '{xb, e.bk};
            end
            chk($sformatf("u%0d_a_valid", i), 16'(av[i]), 16'(e.av));
            chk($sformatf("u%0d_b_valid", i), 16'(bv[i]), 16'(e.bv));
            chk($sformatf("u%0d_coll", i), 16'(co[i]), 16'(e.coll));
            if (ha[i].k) chk($sformatf("u%0d_a_dout", i), ad[i], ha[i].d);
            if (hb[i].k) chk($sformatf("u%0d_b_dout", i), bd[i], hb[i].d);
        end
    endtask

    task automatic step();
        rec_t r;
        bit   ea, eb;
        ea     = a_en && !rst;
        eb     = b_en && !rst;
        r.rst  = rst;
        r.av   = ea;
        r.bv   = eb;
        r.ak   = kn[a_addr];
        r.bk   = kn[b_addr];
        r.a_rf = m[a_addr];
        r.b_rf = m[b_addr];
        r.a_wf = a_we ? mrg(m[a_addr], a_din, a_be) : m[a_addr];
        r.b_wf = b_we ? mrg(m[b_addr], b_din, b_be) : m[b_addr];
        r.coll = ea && eb && (a_addr == b_addr) && (a_we || b_we);
        if (eb && b_we) begin
            m[b_addr]  = mrg(m[b_addr], b_din, b_be);
            kn[b_addr] = kn[b_addr] || (b_be == 2'b11);
        end
        if (ea && a_we) begin
            m[a_addr]  = mrg(m[a_addr], a_din, a_be);
            kn[a_addr] = kn[a_addr] || (a_be == 2'b11);
        end
        sb.push_back(r);
        @(posedge clk);
        #1;
        check_all();
        while (sb.size() > 2) void'(sb.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m[i]  = '0;
            kn[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            ha[i] = '{16'h0, 1'b0};
            hb[i] = '{16'h0, 1'b0};
        end
        rst = 1'b1;
        pa(0, 0, 2'b00, 0, 16'h0);
        pb(0, 0, 2'b00, 0, 16'h0);
        repeat (3) step();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            pa(1, 1, 2'b11, i, pat(i));
            pb(1, 1, 2'b11, i + 8, pat(i + 8));
            step();
        end

        rst = 1'b1;
        pa(1, 1, 2'b11, 2, 16'hFFFF);
        pb(0, 0, 2'b00, 0, 16'h0);
        repeat (2) step();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            pa(1, 0, 2'b11, i, 16'h0);
            step();
        end
        chk("read_back_last", ad[0], pat(15));

        pa(1, 1, 2'b01, 3, 16'hBEEF);
        step();
        pa(0, 0, 2'b00, 0, 16'h0);
        pb(1, 0, 2'b00, 3, 16'h0);
        step();
        chk("be_partial_12EF", bd[0], 16'h12EF);

        pa(1, 1, 2'b11, 5, 16'hAAAA);
        pb(0, 0, 2'b00, 0, 16'h0);
        step();
        chk("rd_first_old", ad[0], 16'h0000);
        chk("wr_first_new", ad[1], 16'hAAAA);

        pa(1, 1, 2'b11, 7, 16'h1111);
        pb(1, 1, 2'b10, 7, 16'h2222);
        step();
        chk("ww_coll", 16'(co[0]), 16'h1);
        pa(1, 0, 2'b00, 7, 16'h0);
        pb(0, 0, 2'b00, 0, 16'h0);
        step();
        chk("ww_a_wins", ad[0], 16'h1111);

        pa(1, 1, 2'b01, 7, 16'h1111);
        pb(1, 1, 2'b10, 7, 16'h2222);
        step();
        pa(1, 0, 2'b00, 7, 16'h0);
        pb(0, 0, 2'b00, 0, 16'h0);
        step();
        chk("ww_byte_mix", ad[0], 16'h2211);

        pa(1, 1, 2'b11, 9, 16'h5A5A);
        pb(1, 0, 2'b00, 9, 16'h0);
        step();
        chk("rw_rd_first_old", bd[0], 16'h0F0F);
        chk("rw_wr_first_old", bd[1], 16'h0F0F);
        chk("rw_coll", 16'(co[1]), 16'h1);
        pa(0, 0, 2'b00, 0, 16'h0);
        step();
        chk("rw_next_new", bd[0], 16'h5A5A);

        pa(1, 0, 2'b00, 4, 16'h0);
        pb(1, 0, 2'b00, 4, 16'h0);
        step();
        chk("rr_no_coll", 16'(co[0]), 16'h0);

        pa(1, 0, 2'b00, 6, 16'h0);
        pb(1, 1, 2'b00, 4, 16'hFFFF);
        step();
        pb(1, 1, 2'b11, 11, 16'hC0DE);
        pa(1, 0, 2'b00, 4, 16'h0);
        step();
        chk("be_zero_noop", ad[0], pat(4));
        pb(0, 0, 2'b00, 0, 16'h0);
        pa(1, 0, 2'b00, 11, 16'h0);
        step();
        chk("b2b_cross_port", ad[0], 16'hC0DE);

        pa(0, 0, 2'b00, 0, 16'h0);
        step();
        for (int i = 0; i < 16; i++) begin
            rst = (i == 5);
            pa(1, 0, 2'b00, i, 16'h0);
            step();
            if (i == 5) chk("oreg_rst_valid", 16'(av[2]), 16'h0);
        end
        rst = 1'b0;
        pa(0, 0, 2'b00, 0, 16'h0);
        step();
        chk("oreg_last", ad[2], pat(15));
        repeat (3) step();
        chk("oreg_hold", ad[2], pat(15));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_be.md
# dpram_be

Parametrised true dual-port RAM with per-byte write enables, selectable read-during-write behaviour and an optional output pipeline stage. It is the successor to the team's 8x8 single-port RAM and generalises width and depth. It adds a second independent port, a defined same-address collision policy, and deterministic outputs when disabled. It sits between two masters sharing a small buffer, for example a producer/consumer pair in the datapath.

## Interface
- DATA_W, 8: data width in bits; must be a multiple of 8.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W words, all addressable.
- RD_MODE, RD_FIRST: read-during-write on the same port; RD_FIRST returns old word, WR_FIRST returns merged new word.
- OUT_REG, 0: 0 gives 1-cycle read latency, 1 adds an output register (2-cycle latency).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_a_en / i_b_en  in  1  port access enable.
- i_a_we / i_b_we  in  1  write enable; write when en&we, read when en&!we.
- i_a_be / i_b_be  in  DATA_W/8  byte enables; bit k qualifies din[8k+7:8k]; ignored on reads.
- i_a_addr / i_b_addr  in  ADDR_W  word address.
- i_a_din / i_b_din  in  DATA_W  write data.
- o_a_dout / o_b_dout  out  DATA_W  read data.
- o_a_valid / o_b_valid  out  1  dout carries the result of an enabled access.
- o_collision  out  1  pulse on a same-address access where at least one port writes; aligned with valid.

## Operation
- Reset: o_*_dout = 0, o_*_valid = 0, o_collision = 0, pipeline registers cleared. Memory contents are not cleared. Writes presented while i_rst=1 are suppressed.
- Write (en&we): only bytes with be=1 are updated; be=0 is a legal no-op write that still produces valid.
- Read (en&!we): dout returns mem[addr] as of before this edge.
- Write on a port also returns data on that port's dout:
  - RD_FIRST: returns the old word.
  - WR_FIRST: returns the old word with the enabled bytes replaced by din.
- Disabled port (en=0): dout holds its last value and valid=0. X is never driven.
- Cross-port collision (both en, same addr, at least one we):
  - Both write: non-overlapping bytes are both applied; port A wins overlapping bytes. o_collision=1.
  - One writes, the other reads: the reader always gets the old word, independent of RD_MODE. o_collision=1.
  - Both read same address: no collision; both return the same word.
- Different addresses: ports are fully independent with no stall or arbitration.

## Timing
- OUT_REG=0: access at edge N; dout/valid/collision visible after edge N (readable in cycle N+1).
- OUT_REG=1: one more edge; the output stage holds on valid=0 and never bubbles data.
- Full throughput: one access per port per cycle, back-to-back, including a read of an address written the previous cycle on either port, which returns the new data.
- Reset asserted mid-stream: at the next edge all valids and o_collision go to 0 and in-flight OUT_REG data is discarded. The first access after reset deasserts completes with normal latency.

## Structure
- Package dpram_pkg holds:
  - typedef enum rd_mode_e {RD_FIRST, WR_FIRST};
  - function byte_merge(old, new, be), used by both the write path and WR_FIRST return.
- Sub-module dpram_out_stage: per-port output register (dout, valid), generate-bypassed when OUT_REG=0. It is instantiated twice; o_collision uses an equivalent 1-bit stage.
- Memory array reg [DATA_W-1:0] mem [0:DEPTH-1] sits in the top level. Port writes are ordered B then A so that A wins.

## Test plan
All scenarios use DATA_W=16, ADDR_W=4.
- Reset, then read addr 0..15 on A with no prior writes -> valid=1 each cycle after latency; dout matches the preloaded backdoor pattern. Outputs are 0 and valid=0 during reset.
- A writes 16'hBEEF to addr 3 with be=2'b01, having preloaded 16'h1234 -> B reads addr 3 next cycle and gets 16'h12EF.
- Same-port write to addr 5 (old 16'h0000), din 16'hAAAA, be=2'b11:
  - RD_FIRST: dout=16'h0000.
  - WR_FIRST: dout=16'hAAAA.
- Same cycle, A writes 16'h1111 be=2'b11 and B writes 16'h2222 be=2'b10 to addr 7 -> o_collision=1; mem[7]=16'h1111.
  - Repeat with A be=2'b01 -> mem[7]=16'h2211.
- A writes 16'h5A5A to addr 9 while B reads addr 9 (old 16'h0F0F), both RD_MODE values -> B dout=16'h0F0F; o_collision=1. Next-cycle B read returns 16'h5A5A.
- OUT_REG=1, continuous A reads of 0..15 with i_rst pulsed at the 6th cycle -> valid drops for the reset cycle, no stale word appears, reads resume with 2-cycle latency; i_en=0 afterwards holds dout.
